// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC capture path.
// Holds the sample RAM geometry and the sample writer state encoding.
package mfcc_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sample_ram_writer_if.sv
// Sample stream in / RAM write port out bundle for sample_ram_writer.
// Signals:
//   in_valid, in_data          : PCM sample stream from the audio source
//   ram_we, ram_addr, ram_wdata: write port into the shared sample RAM
// master = writer side (consumes samples, drives RAM); slave = environment.
interface sample_ram_writer_if;
    import mfcc_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

endinterface

// File: rtl/sample_decim.sv
// Decimate-by-2 selector for the sample writer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_acc  : capture start was accepted this cycle
//   fs_control : 1 = keep every sample, 0 = keep every 2nd sample
//   in_valid   : a sample is present this cycle
//   keep       : combinational, this sample is one to be stored
module sample_decim (
    input  logic clk,
    input  logic rst,
    input  logic start_acc,
    input  logic fs_control,
    input  logic in_valid,
    output logic keep
);

    logic fs_q;
    logic ph;

    // Rate select is latched once per capture; phase restarts so the first sample is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_q <= 1'b1;
            ph   <= 1'b0;
        end else if (start_acc) begin
            fs_q <= fs_control;
            ph   <= 1'b0;
        end else if (in_valid && !fs_q) begin
            ph <= ~ph;
        end
    end

    assign keep = in_valid & (fs_q | ~ph);

endmodule

// File: rtl/sample_ram_writer.sv
// Capture front end for the MFCC extractor: writes FILL_LEN (optionally
// decimated) PCM samples sequentially into the shared sample RAM, then
// holds the buffer with ready=1 until fefinish re-arms the block.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : pulse that begins a capture (IDLE only)
//   fs_control  : rate select sampled at the accepted start
//   fefinish    : MFCC done with the buffer
//   bus         : sample stream in, RAM write port out
//   ready       : buffer full and valid
//   busy        : capture in progress
//   overrun     : sticky, a kept sample was dropped while the buffer was full
module sample_ram_writer
    import mfcc_pkg::*;
#(
    parameter int unsigned FILL_LEN = 16000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                fs_control,
    input  logic                fefinish,
    sample_ram_writer_if.master bus,
    output logic                ready,
    output logic                busy,
    output logic                overrun
);

    // One extra bit so a full 2**ADDR_W capture does not wrap the count.
    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILL_LEN - 1);

    wr_state_t        state;
    logic [CNT_W-1:0] wcnt;
    logic             start_acc;
    logic             keep;

    assign start_acc = (state == IDLE) && start;

    sample_decim u_decim (
        .clk        (clk),
        .rst        (rst),
        .start_acc  (start_acc),
        .fs_control (fs_control),
        .in_valid   (bus.in_valid),
        .keep       (keep)
    );

    // Capture FSM with the write counter and registered RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            ready         <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            bus.ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        wcnt    <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                FILL: begin
                    if (keep) begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= wcnt[ADDR_W-1:0];
                        bus.ram_wdata <= bus.in_data;
                        wcnt          <= wcnt + CNT_W'(1);
                        if (wcnt == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Buffer is frozen; any sample that would have been stored is lost.
                    if (keep) begin
                        overrun <= 1'b1;
                    end
                    if (fefinish) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
